fetch_unit: RTL and testbench
=============================

# fetch_unit

In-order RISC-V instruction fetch stage sitting directly upstream of the decoder. Generates sequential PCs, issues word requests to instruction memory over a valid/ready request channel, buffers returned words with their addresses in a small FIFO, and presents `inst`/`inst_addr` to the decoder through a valid/ready handshake. A redirect input (branch/jump target) flushes buffered and in-flight instructions and restarts fetch at the new address.

## Interface
- `RESET_ADDR`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2. Also bounds in-flight requests.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  word address of request (bits [1:0] = 0).
- `imem_resp_valid`  in  1  response word valid; responses return in request order, no backpressure.
- `imem_resp_data`  in  32  returned instruction word.
- `redirect_valid`  in  1  single-cycle flush/restart pulse.
- `redirect_addr`  in  32  new fetch address.
- `inst_valid`  out  1  FIFO head valid toward decoder.
- `inst_ready`  in  1  decoder consumes head this cycle.
- `inst`  out  32  head instruction word.
- `inst_addr`  out  32  address of head instruction.
- `fetch_misaligned`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `pc` (next request address), `resp_pc` (address of next accepted response), FIFO of {addr, word}, `count`, `outstanding` (requests accepted, response pending), `drop_cnt` (stale responses to discard), `halted`.
- `req_fire` = `imem_req_valid & imem_req_ready`; `resp_fire` = `imem_resp_valid`; `pop` = `inst_valid & inst_ready`.
- `imem_req_valid` = `!halted & (count + outstanding < FIFO_DEPTH)`; credit rule guarantees every response has a free slot, so responses are never refused.
- `imem_req_addr` = `pc`; on `req_fire`, `pc <= pc + 4` (mod 2^32, wraps 0xFFFF_FFFC → 0).
- On `resp_fire` with `drop_cnt == 0`: push {`resp_pc`, `imem_resp_data`}, `resp_pc <= resp_pc + 4`. With `drop_cnt > 0`: discard, `drop_cnt <= drop_cnt - 1`.
- `outstanding` += `req_fire`, −= `resp_fire` (dropped responses included).
- Push and pop in the same cycle: `count` unchanged; head advances.
- Redirect cycle (`redirect_valid`), highest priority: FIFO cleared (`count <= 0`, pop in this cycle ignored), `pc <= redirect_addr`, `resp_pc <= redirect_addr`, `drop_cnt <= outstanding + req_fire - resp_fire`. A request accepted or response arriving in the redirect cycle is stale.
- Redirect while `drop_cnt > 0`: recomputed per above; all in-flight responses still discarded.
- Reset overrides everything, including a concurrent redirect.

## Timing
- Reset values: `imem_req_valid` 0 during reset cycle, `imem_req_addr` = `RESET_ADDR`, `inst_valid` 0, `inst` 0, `inst_addr` 0, `fetch_misaligned` 0; `count`, `outstanding`, `drop_cnt`, `halted` 0.
- First request: cycle after `rst` deasserts, address `RESET_ADDR`.
- Response → `inst_valid`: 1 cycle (registered FIFO write, head read combinationally from storage).
- Redirect → first new request: next cycle, address `redirect_addr`.
- Sustained throughput 1 instruction/cycle when `FIFO_DEPTH` ≥ memory latency + 1 and decoder always ready.
- `inst`/`inst_addr` stable while `inst_valid & !inst_ready` (absent redirect).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_addr[1:0] != 0` sets `halted` and `fetch_misaligned` (both sticky); no further requests; stale responses still drained. Next aligned redirect or reset clears both and restarts fetch.
- Undefined: `redirect_addr[1:0]` forced to 0; `fetch_misaligned` tied 0; `halted` never set.

## Test plan
- Reset, memory 1-cycle latency, decoder always ready → requests 0x0,0x4,0x8…; `inst_addr` sequence 0x0,0x4,0x8 at 1 per cycle; first `inst_valid` 2 cycles after reset release.
- Decoder stalls (`inst_ready`=0) → after 4 entries + 0 outstanding, `imem_req_valid` low; `inst`/`inst_addr` held; releasing stall resumes with no lost/duplicated words.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x100 → 3 responses discarded, next `inst_addr` 0x100 with word from 0x100.
- Redirect in same cycle as request accept and response arrival → both treated stale; no stale word reaches `inst`.
- `pc` = 0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → `fetch_misaligned`=1, no requests; redirect to 0x200 → flag clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order RISC-V fetch stage; credit-limited imem requests feed a small {addr,word} FIFO toward decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and raises sticky fetch_misaligned.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        fetch_misaligned
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] fifo_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt, outstanding_nxt;
  logic [CW:0]   credit_used;
  logic [31:0]   pc, resp_pc, redir_tgt;
  logic          halted, redir_bad;
  logic          req_fire, resp_fire, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt        = redirect_addr;
  assign redir_bad        = (redirect_addr[1:0] != 2'b00);
  assign fetch_misaligned = halted;
`else
  logic unused_lo;
  assign unused_lo        = ^redirect_addr[1:0];
  assign redir_tgt        = {redirect_addr[31:2], 2'b00};
  assign redir_bad        = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // Every accepted request owns a FIFO slot, so responses can never be refused.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !halted && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_fire = imem_resp_valid;
  assign push      = resp_fire && (drop_cnt == '0);
  assign pop       = inst_valid & inst_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);

  assign inst_valid = (count != '0);
  assign inst       = fifo_q[rd_ptr].word;
  assign inst_addr  = fifo_q[rd_ptr].addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_q      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight, including this cycle's accept/response, is stale.
        pc       <= redir_tgt;
        resp_pc  <= redir_tgt;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop_cnt <= outstanding_nxt;
        halted   <= redir_bad;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (push) begin
          fifo_q[wr_ptr] <= '{addr: resp_pc, word: imem_resp_data};
          wr_ptr         <= wr_ptr + AW'(1);
          resp_pc        <= resp_pc + 32'd4;
        end
        if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized + directed checks of fetch_unit against an epoch-tagged transaction model.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RA    = 32'h0000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_addr;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_ADDR(RA), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_addr(inst_addr),
    .fetch_misaligned(fetch_misaligned)
  );

  // In-flight memory request: address, fetch epoch it was issued in, cycle its response is due.
  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] bufq[$];
  logic [31:0] pc_m = RA;
  int          ep = 0, cyc = 0, last_due = 0, lat = 1;
  bit          halt_m = 0, mis_m = 0;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare DUT against model, then advance the model across the edge.
  task automatic step(input bit r, input bit rv, input logic [31:0] ra, input bit ir, input bit qr);
    bit    req_v, req_f, resp, pop;
    mreq_t e;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_addr = ra; inst_ready = ir; imem_req_ready = qr;
    resp = !r && memq.size() > 0 && memq[0].due <= cyc;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(memq[0].addr) : $urandom;
    #1;
    req_v = !r && !halt_m && (bufq.size() + memq.size() < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, req_v});
    if (!r) begin
      if (req_v) chk("req_addr", imem_req_addr, pc_m);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, bufq.size() > 0});
      if (bufq.size() > 0) begin
        chk("inst_addr", inst_addr, bufq[0]);
        chk("inst", inst, mem_word(bufq[0]));
      end
      chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, mis_m});
    end
    req_f = req_v && qr;
    pop   = bufq.size() > 0 && ir;
    if (r) begin
      memq.delete(); bufq.delete();
      pc_m = RA; halt_m = 0; mis_m = 0; ep++; last_due = cyc;
    end else begin
      if (resp) e = memq.pop_front();
      if (rv) bufq.delete();
      else begin
        if (pop) void'(bufq.pop_front());
        if (resp && e.ep == ep) bufq.push_back(e.addr);
      end
      if (req_f) begin
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        memq.push_back('{pc_m, ep, last_due});
        pc_m += 32'd4;
      end
      if (rv) begin
        ep++;
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_m = (ra[1:0] != 2'b00);
        mis_m  = halt_m;
        pc_m   = ra;
`else
        pc_m   = {ra[31:2], 2'b00};
`endif
      end
    end
    cyc++;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin step(0, 0, 0, 1, 1); n++; end while (!inst_valid && n < 20);
    n_chk++;
    if (!inst_valid) begin
      n_fail++;
      $display("FAIL %s: inst_valid never rose, got 0, expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    logic [31:0] ra;
    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, RA);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);

    // 1-cycle memory, decoder always ready: first inst two cycles after release, then 1/cycle
    lat = 1;
    step(0, 0, 0, 1, 1); chk("first_req_addr", imem_req_addr, 32'h0);
    step(0, 0, 0, 1, 1); chk("seq_v1", {31'b0, inst_valid}, 32'h0);
    step(0, 0, 0, 1, 1); chk("seq_a0", inst_addr, 32'h0);
    step(0, 0, 0, 1, 1); chk("seq_a4", inst_addr, 32'h4);
    step(0, 0, 0, 1, 1); chk("seq_a8", inst_addr, 32'h8);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    // Decoder stall fills the FIFO and throttles requests
    step(0, 1, 32'h40, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("stall_addr", inst_addr, 32'h40);
    chk("stall_inst", inst, mem_word(32'h40));
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

    // 3-cycle memory with requests in flight, then redirect
    lat = 3;
    step(0, 1, 32'h80, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h100, 1, 1);
    wait_valid("redir_100");
    chk("redir_100_addr", inst_addr, 32'h100);
    chk("redir_100_inst", inst, mem_word(32'h100));

    // Redirect coinciding with request accept and response arrival
    lat = 1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h300, 1, 1);
    wait_valid("redir_300");
    chk("redir_300_addr", inst_addr, 32'h300);

    // PC wrap
    step(0, 1, 32'hFFFF_FFF8, 1, 1);
    wait_valid("wrap");
    chk("wrap_a0", inst_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 1, 1); chk("wrap_a1", inst_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1); chk("wrap_a2", inst_addr, 32'h0000_0000);

    // Misaligned redirect
    step(0, 1, 32'h102, 1, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    chk("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
    chk("mis_no_req", {31'b0, imem_req_valid}, 32'h0);
    step(0, 1, 32'h200, 1, 1);
    wait_valid("mis_recover");
    chk("mis_recover_addr", inst_addr, 32'h200);
    chk("mis_cleared", {31'b0, fetch_misaligned}, 32'h0);
`else
    wait_valid("mis_forced");
    chk("mis_forced_addr", inst_addr, 32'h100);
    chk("mis_tied0", {31'b0, fetch_misaligned}, 32'h0);
`endif

    // Reset wins over a concurrent redirect
    step(1, 1, 32'h500, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_over_redir_v", {31'b0, imem_req_valid}, 32'h1);
    chk("rst_over_redir_a", imem_req_addr, RA);

    // Randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      lat = $urandom_range(4, 1);
      for (int i = 0; i < 400; i++) begin
        ra = $urandom;
        if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
        step(0, $urandom_range(99) < 3, ra, $urandom_range(99) < 70, $urandom_range(99) < 70);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
